harness_run_monitor: RTL and testbench

- Sits directly upstream and downstream of the SoC TestHarness in simulation top-levels.
- Upstream role: generates the harness reset, held for a fixed number of cycles after the bench reset releases.
- Downstream role: consumes the harness io_success flag and reports pass/fail, a timeout verdict and the elapsed run cycles, so benches stop on a verdict instead of a fixed delay.

---
 rtl/harness_run_monitor_pkg.sv | 17 +
 rtl/harness_run_monitor_sat_counter.sv | 28 ++
 rtl/harness_run_monitor.sv | 154 +++++++++++++++
 tb/tb_harness_run_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/harness_run_monitor_pkg.sv
// Shared types and constants for the harness run monitor.
package harness_run_monitor_pkg;

  // Monitor phases: reset hold, running, and the two terminal verdicts.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  // Failure reason reported on fail_code; 2'b11 is reserved.
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_STALL   = 2'b10;

endpackage

// File: rtl/harness_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;

  // Count register: clear wins over increment; stick at the maximum value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q = count_q;

endmodule

// File: rtl/harness_run_monitor.sv
// Harness run monitor: generates the TestHarness reset and turns the harness
// io_success flag into a sticky pass/fail verdict with timeout detection.
// Optional stall watchdog on io_progress: define HARNESS_STALL_WATCHDOG_EN.
module harness_run_monitor
  import harness_run_monitor_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned STALL_CYCLES   = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_success,
  input  logic             io_progress,
  output logic             harness_reset,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RESET_CYCLES - 1);
  localparam bit               TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = TimeoutEn ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e     state_q, state_d;
  logic       harness_reset_q, harness_reset_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic [1:0] fail_code_q, fail_code_d;

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_last;
  logic             timeout_hit;
  logic             stall_hit;
  logic             run_continue;

  // Hold counter only advances in HOLD and is parked at zero otherwise.
  sat_counter #(
    .W (CNT_W)
  ) u_hold_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != HOLD),
    .inc   (state_q == HOLD),
    .q     (hold_cnt)
  );

  // Run cycles only count on edges that stay in RUN, so the value is frozen
  // at whatever it was when the verdict edge sampled it.
  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (run_continue),
    .q     (cycle_count)
  );

  assign hold_last    = (hold_cnt == HoldLast);
  assign timeout_hit  = TimeoutEn && (cycle_count == TimeoutLast);
  assign run_continue = (state_q == RUN) && (state_d == RUN);

`ifdef HARNESS_STALL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] StallLast = CNT_W'(STALL_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;

  // Stall counter restarts on every progress pulse and outside RUN.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   ((state_q != RUN) || io_progress),
    .inc   (state_q == RUN),
    .q     (stall_cnt)
  );

  assign stall_hit = (state_q == RUN) && !io_progress && (stall_cnt == StallLast);
`else
  logic unused_stall_cfg;

  assign unused_stall_cfg = io_progress ^ (^STALL_CYCLES);
  assign stall_hit        = 1'b0;
`endif

  // Next state and next registered outputs; priority success > timeout > stall.
  always_comb begin
    state_d         = state_q;
    harness_reset_d = harness_reset_q;
    pass_d          = pass_q;
    fail_d          = fail_q;
    fail_code_d     = fail_code_q;
    unique case (state_q)
      HOLD: begin
        if (hold_last) begin
          state_d         = RUN;
          harness_reset_d = 1'b0;
        end
      end
      RUN: begin
        if (io_success) begin
          state_d = PASS;
          pass_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d     = FAIL;
          fail_d      = 1'b1;
          fail_code_d = FC_TIMEOUT;
        end else if (stall_hit) begin
          state_d     = FAIL;
          fail_d      = 1'b1;
          fail_code_d = FC_STALL;
        end
      end
      PASS, FAIL: begin
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    done_d = pass_d | fail_d;
  end

  // State and output registers; reset returns to a fresh HOLD immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= HOLD;
      harness_reset_q <= 1'b1;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      fail_code_q     <= FC_NONE;
    end else begin
      state_q         <= state_d;
      harness_reset_q <= harness_reset_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      fail_code_q     <= fail_code_d;
    end
  end

  assign harness_reset = harness_reset_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign fail_code     = fail_code_q;

endmodule

// File: tb/tb_harness_run_monitor.sv
// Directed bench for harness_run_monitor: reset hold, pass, timeout, priority,
// asynchronous reset mid-run, stall watchdog and counter saturation.
module tb_harness_run_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_success;
  logic        io_progress;
  logic        harness_reset;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;

  // Second instance: narrow counter, timeout disabled, minimum hold length.
  logic        harness_reset2;
  logic        done2;
  logic        pass2;
  logic        fail2;
  logic [1:0]  fail_code2;
  logic [3:0]  cycle_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  harness_run_monitor #(
    .RESET_CYCLES   (20),
    .TIMEOUT_CYCLES (1000),
    .CNT_W          (32),
    .STALL_CYCLES   (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_success    (io_success),
    .io_progress   (io_progress),
    .harness_reset (harness_reset),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count)
  );

  harness_run_monitor #(
    .RESET_CYCLES   (1),
    .TIMEOUT_CYCLES (0),
    .CNT_W          (4),
    .STALL_CYCLES   (4096)
  ) dut_sat (
    .clock         (clock),
    .reset         (reset),
    .io_success    (1'b0),
    .io_progress   (1'b1),
    .harness_reset (harness_reset2),
    .done          (done2),
    .pass          (pass2),
    .fail          (fail2),
    .fail_code     (fail_code2),
    .cycle_count   (cycle_count2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_verdict(input string tag, input logic exp_pass, input logic exp_fail,
                               input logic [1:0] exp_code, input logic [31:0] exp_cnt);
    check({tag, ".pass"}, 64'(pass), 64'(exp_pass));
    check({tag, ".fail"}, 64'(fail), 64'(exp_fail));
    check({tag, ".done"}, 64'(done), 64'(exp_pass | exp_fail));
    check({tag, ".fail_code"}, 64'(fail_code), 64'(exp_code));
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'(exp_cnt));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called 1ns after an edge: pulse reset between edges, then verify the hold.
  task automatic restart(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".async_hr"}, 64'(harness_reset), 64'd1);
    check_verdict({tag, ".async"}, 1'b0, 1'b0, 2'b00, 32'd0);
    #1;
    reset = 1'b0;
    tick(19);
    check({tag, ".hold19_hr"}, 64'(harness_reset), 64'd1);
    check({tag, ".hold19_cnt"}, 64'(cycle_count), 64'd0);
    tick(1);
    check({tag, ".hold20_hr"}, 64'(harness_reset), 64'd0);
    check({tag, ".hold20_cnt"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    io_success  = 1'b0;
    io_progress = 1'b1;

    // Reset state
    #50;
    check("rst.hr", 64'(harness_reset), 64'd1);
    check_verdict("rst", 1'b0, 1'b0, 2'b00, 32'd0);
    check("rst.hr2", 64'(harness_reset2), 64'd1);

    // Release at 200ns; edges at 205, 215, ... so edge 20 lands at 395ns
    #150;
    reset = 1'b0;
    tick(19);
    check("hold.hr_edge19", 64'(harness_reset), 64'd1);
    check_verdict("hold.edge19", 1'b0, 1'b0, 2'b00, 32'd0);
    // dut_sat left HOLD at edge 1, then counted 18 edges: saturates at 15
    check("sat.hr", 64'(harness_reset2), 64'd0);
    check("sat.cnt", 64'(cycle_count2), 64'd15);
    tick(1);
    check("hold.hr_edge20", 64'(harness_reset), 64'd0);
    check("hold.cnt_edge20", 64'(cycle_count), 64'd0);

    // Success at RUN cycle 500 for one clock
    tick(500);
    check_verdict("run500", 1'b0, 1'b0, 2'b00, 32'd500);
    io_success = 1'b1;
    tick(1);
    io_success = 1'b0;
    check_verdict("pass", 1'b1, 1'b0, 2'b00, 32'd500);
    tick(100);
    check_verdict("pass_frozen", 1'b1, 1'b0, 2'b00, 32'd500);
    check("pass.hr_low", 64'(harness_reset), 64'd0);

    // Timeout with io_success held low
    restart("rst_from_pass");
    tick(999);
    check_verdict("to.before", 1'b0, 1'b0, 2'b00, 32'd999);
    tick(1);
    check_verdict("to.edge", 1'b0, 1'b1, 2'b01, 32'd999);
    tick(10);
    check_verdict("to.frozen", 1'b0, 1'b1, 2'b01, 32'd999);

    // Success on the exact timeout edge wins
    restart("rst_from_fail");
    tick(999);
    io_success = 1'b1;
    tick(1);
    io_success = 1'b0;
    check_verdict("to.success_wins", 1'b1, 1'b0, 2'b00, 32'd999);

    // Reset mid-RUN at cycle 300 clears asynchronously and repeats the hold
    restart("rst_from_pass2");
    tick(300);
    check_verdict("run300", 1'b0, 1'b0, 2'b00, 32'd300);
    restart("rst_mid_run");

    // Progress every 50 cycles, then silence
    io_progress = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(49);
      io_progress = 1'b1;
      tick(1);
      io_progress = 1'b0;
    end
    tick(63);
    check_verdict("stall.before", 1'b0, 1'b0, 2'b00, 32'd263);
    tick(1);
`ifdef HARNESS_STALL_WATCHDOG_EN
    check_verdict("stall.edge", 1'b0, 1'b1, 2'b10, 32'd263);
    tick(800);
    check_verdict("stall.frozen", 1'b0, 1'b1, 2'b10, 32'd263);
`else
    check_verdict("nostall.edge", 1'b0, 1'b0, 2'b00, 32'd264);
    tick(735);
    check_verdict("nostall.to_before", 1'b0, 1'b0, 2'b00, 32'd999);
    tick(1);
    check_verdict("nostall.to_edge", 1'b0, 1'b1, 2'b01, 32'd999);
`endif

    // Timeout-disabled instance never reaches a verdict
    check("sat.fail", 64'(fail2), 64'd0);
    check("sat.done", 64'(done2), 64'd0);
    check("sat.cnt_end", 64'(cycle_count2), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
